// File: rtl/alu_issue_stage.sv
// Issue stage between the thread dispatcher and the ALU lanes: steers each lane's
// selected thread into a per-lane issue register, acks the thread, absorbs stalls.
module alu_issue_stage #(
  parameter  int NUM_Threads = 4,
  parameter  int NUM_ALUs    = 4,
  localparam int XLEN        = 32,
  localparam int TID_W       = $clog2(NUM_Threads)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             dispatch_threads [NUM_ALUs],
  input  logic [6:0]             oh_in            [NUM_Threads],
  input  logic [XLEN-1:0]        thr_rs1          [NUM_Threads],
  input  logic [XLEN-1:0]        thr_rs2          [NUM_Threads],
  input  logic [4:0]             thr_rd           [NUM_Threads],
  input  logic [XLEN-1:0]        thr_pc           [NUM_Threads],
  input  logic [NUM_ALUs-1:0]    alu_stall,
  output logic [NUM_ALUs-1:0]    iss_valid,
  output logic [TID_W-1:0]       iss_tid          [NUM_ALUs],
  output logic [6:0]             iss_op           [NUM_ALUs],
  output logic [XLEN-1:0]        iss_a            [NUM_ALUs],
  output logic [XLEN-1:0]        iss_b            [NUM_ALUs],
  output logic [4:0]             iss_rd           [NUM_ALUs],
  output logic [XLEN-1:0]        iss_pc           [NUM_ALUs],
  output logic [NUM_Threads-1:0] thr_ack,
  output logic                   dup_err,
  output logic [31:0]            perf_issued
);

  localparam logic [2:0] NT = 3'(NUM_Threads);

  logic [NUM_ALUs-1:0]    r_vld_p1;
  logic [TID_W-1:0]       r_tid_p1 [NUM_ALUs];
  logic [6:0]             r_op_p1  [NUM_ALUs];
  logic [XLEN-1:0]        r_a_p1   [NUM_ALUs];
  logic [XLEN-1:0]        r_b_p1   [NUM_ALUs];
  logic [4:0]             r_rd_p1  [NUM_ALUs];
  logic [XLEN-1:0]        r_pc_p1  [NUM_ALUs];
  logic                   r_dup;
  logic [31:0]            r_perf;

  logic [NUM_ALUs-1:0]    w_load;
  logic [NUM_ALUs-1:0]    w_req;
  logic [NUM_ALUs-1:0]    w_acc;
  logic [TID_W-1:0]       w_tid [NUM_ALUs];
  logic [NUM_Threads-1:0] w_claim;
  logic [NUM_Threads-1:0] w_ack;
  logic                   w_dup;
  logic [31:0]            w_cnt;

  // Stage p0: lane selection, duplicate resolution in lane-priority order
  always_comb begin
    w_claim = '0;
    w_ack   = '0;
    w_dup   = 1'b0;
    w_cnt   = '0;
    for (int j = 0; j < NUM_ALUs; j++) begin
      w_load[j] = !r_vld_p1[j] || !alu_stall[j];
      w_acc[j]  = 1'b0;
      w_tid[j]  = dispatch_threads[j][TID_W-1:0];
      w_req[j]  = (dispatch_threads[j] < NT) && (oh_in[w_tid[j]] != 7'd0);
      if (w_req[j]) begin
        if (w_claim[w_tid[j]]) begin
          w_dup = 1'b1;
        end else if (w_load[j]) begin
          // Blocked lanes never claim, so a higher lane may still take the thread.
          w_acc[j]             = 1'b1;
          w_claim[w_tid[j]]    = 1'b1;
          w_ack[w_tid[j]]      = 1'b1;
          w_cnt                = w_cnt + 32'd1;
        end
      end
    end
    if (rst) begin
      w_ack = '0;
    end
  end

  assign thr_ack = w_ack;

  // Stage p1: issue registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= '0;
      r_dup    <= 1'b0;
      r_perf   <= '0;
      for (int j = 0; j < NUM_ALUs; j++) begin
        r_tid_p1[j] <= '0;
        r_op_p1[j]  <= '0;
        r_a_p1[j]   <= '0;
        r_b_p1[j]   <= '0;
        r_rd_p1[j]  <= '0;
        r_pc_p1[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_ALUs; j++) begin
        if (w_load[j]) begin
          r_vld_p1[j] <= w_acc[j];
          if (w_acc[j]) begin
            r_tid_p1[j] <= w_tid[j];
            r_op_p1[j]  <= oh_in[w_tid[j]];
            r_a_p1[j]   <= thr_rs1[w_tid[j]];
            r_b_p1[j]   <= thr_rs2[w_tid[j]];
            r_rd_p1[j]  <= thr_rd[w_tid[j]];
            r_pc_p1[j]  <= thr_pc[w_tid[j]];
          end
        end
      end
      r_perf <= r_perf + w_cnt;
      if (w_dup) begin
        r_dup <= 1'b1;
      end
    end
  end

  assign iss_valid   = r_vld_p1;
  assign iss_tid     = r_tid_p1;
  assign iss_op      = r_op_p1;
  assign iss_a       = r_a_p1;
  assign iss_b       = r_b_p1;
  assign iss_rd      = r_rd_p1;
  assign iss_pc      = r_pc_p1;
  assign dup_err     = r_dup;
  assign perf_issued = r_perf;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a driver queues hand-derived expectations
// per cycle, a monitor checks the ack in that cycle and the issue state one cycle later.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic [2:0]  dispatch_threads [4];
  logic [6:0]  oh_in   [4];
  logic [31:0] thr_rs1 [4];
  logic [31:0] thr_rs2 [4];
  logic [4:0]  thr_rd  [4];
  logic [31:0] thr_pc  [4];
  logic [3:0]  alu_stall;
  logic [3:0]  iss_valid;
  logic [1:0]  iss_tid [4];
  logic [6:0]  iss_op  [4];
  logic [31:0] iss_a   [4];
  logic [31:0] iss_b   [4];
  logic [4:0]  iss_rd  [4];
  logic [31:0] iss_pc  [4];
  logic [3:0]  thr_ack;
  logic        dup_err;
  logic [31:0] perf_issued;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .dispatch_threads(dispatch_threads), .oh_in(oh_in),
    .thr_rs1(thr_rs1), .thr_rs2(thr_rs2), .thr_rd(thr_rd), .thr_pc(thr_pc),
    .alu_stall(alu_stall), .iss_valid(iss_valid), .iss_tid(iss_tid), .iss_op(iss_op),
    .iss_a(iss_a), .iss_b(iss_b), .iss_rd(iss_rd), .iss_pc(iss_pc),
    .thr_ack(thr_ack), .dup_err(dup_err), .perf_issued(perf_issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Thread t presents op t+1; operand fields are tagged with a generation number
  int gen;
  logic oh2z;
  always_comb begin
    for (int t = 0; t < 4; t++) begin
      oh_in[t]   = (oh2z && t == 2) ? 7'd0 : 7'(t + 1);
      thr_rs1[t] = 32'(t * 16 + gen * 256);
      thr_rs2[t] = 32'(256 + t + gen);
      thr_rd[t]  = 5'(t + 8);
      thr_pc[t]  = 32'(4096 + t * 4 + gen * 8);
    end
  end

  typedef struct packed {
    logic [3:0]        ack;
    logic [3:0]        vld;
    logic [3:0]        dmask;
    logic              dup;
    logic [31:0]       perf;
    logic [3:0][109:0] ld;
  } exp_t;

  exp_t              q[$];
  logic [3:0][109:0] exp_ld;
  int                n_cmp;
  int                n_err;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic lane(input int l, input int t, input int g);
    exp_ld[l] = {2'(t), 7'(t + 1), 32'(t * 16 + g * 256), 32'(256 + t + g), 5'(t + 8),
                 32'(4096 + t * 4 + g * 8)};
  endtask

  task automatic zero_lanes();
    exp_ld = '0;
  endtask

  task automatic step(input logic r, input int g, input logic z, input logic [3:0][2:0] dt,
                      input logic [3:0] stall, input logic [3:0] eack, input logic [3:0] evld,
                      input logic [3:0] dmask, input logic edup, input logic [31:0] eperf);
    exp_t e;
    @(posedge clk);
    #1;
    rst  = r;
    gen  = g;
    oh2z = z;
    for (int l = 0; l < 4; l++) dispatch_threads[l] = dt[l];
    alu_stall = stall;
    e.ack   = eack;
    e.vld   = evld;
    e.dmask = dmask;
    e.dup   = edup;
    e.perf  = eperf;
    e.ld    = exp_ld;
    q.push_back(e);
  endtask

  // Monitor
  exp_t pend;
  bit   have;
  initial begin
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (have) begin
        chk("iss_valid", 128'(iss_valid), 128'(pend.vld));
        chk("dup_err", 128'(dup_err), 128'(pend.dup));
        chk("perf_issued", 128'(perf_issued), 128'(pend.perf));
        for (int l = 0; l < 4; l++) begin
          if (pend.dmask[l])
            chk($sformatf("lane%0d", l),
                128'({iss_tid[l], iss_op[l], iss_a[l], iss_b[l], iss_rd[l], iss_pc[l]}),
                128'(pend.ld[l]));
        end
        have = 1'b0;
      end
      if (q.size() > 0) begin
        pend = q.pop_front();
        chk("thr_ack", 128'(thr_ack), 128'(pend.ack));
        have = 1'b1;
      end
    end
  end

  // Driver
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    gen = 0;
    oh2z = 1'b0;
    alu_stall = '0;
    for (int l = 0; l < 4; l++) dispatch_threads[l] = 3'd4;
    exp_ld = '0;

    zero_lanes();
    step(1, 0, 0, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, {3'd4, 3'd4, 3'd4, 3'd4}, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);

    for (int l = 0; l < 4; l++) lane(l, l, 0);
    step(0, 0, 0, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 0, 4);

    lane(0, 3, 1); lane(1, 2, 1); lane(3, 0, 1);
    step(0, 1, 0, {3'd0, 3'd1, 3'd2, 3'd3}, 4'b0100, 4'b1101, 4'b1111, 4'b1111, 0, 7);

    for (int g = 2; g <= 4; g++)
      step(0, g, 0, {3'd4, 3'd3, 3'd4, 3'd4}, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 0, 7);
    lane(2, 3, 5);
    step(0, 5, 0, {3'd4, 3'd3, 3'd4, 3'd4}, 4'b0000, 4'b1000, 4'b0100, 4'b0100, 0, 8);

    lane(0, 1, 6);
    step(0, 6, 0, {3'd4, 3'd4, 3'd4, 3'd1}, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 0, 9);
    lane(1, 2, 7);
    step(0, 7, 0, {3'd4, 3'd4, 3'd2, 3'd2}, 4'b0001, 4'b0100, 4'b0011, 4'b0011, 0, 10);

    lane(0, 1, 8);
    step(0, 8, 0, {3'd4, 3'd4, 3'd1, 3'd1}, 4'b0000, 4'b0010, 4'b0001, 4'b0001, 1, 11);
    step(0, 9, 1, {3'd4, 3'd4, 3'd4, 3'd2}, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 11);

    for (int l = 0; l < 4; l++) lane(l, l, 10);
    step(0, 10, 0, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 1, 15);
    lane(0, 3, 11);
    step(0, 11, 0, {3'd3, 3'd3, 3'd3, 3'd3}, 4'b0000, 4'b1000, 4'b0001, 4'b0001, 1, 16);
    step(0, 12, 0, {3'd4, 3'd6, 3'd7, 3'd5}, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 16);

    for (int l = 0; l < 4; l++) lane(l, l, 13);
    step(0, 13, 0, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 1, 20);
    lane(0, 1, 14); lane(1, 2, 14); lane(2, 3, 14); lane(3, 0, 14);
    step(0, 14, 0, {3'd0, 3'd3, 3'd2, 3'd1}, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 1, 24);

    zero_lanes();
    step(1, 15, 0, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 0);
    step(0, 16, 0, {3'd4, 3'd4, 3'd4, 3'd4}, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0 || have) begin
      n_err++;
      $display("FAIL drain: got %0d pending required 0", q.size() + int'(have));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
